// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the pipeline control slice.
//   ctrl_state_t       - controller FSM states
//   REG_AW / NUM_REGS  - register-bank address width and depth
//   XLEN               - datapath width (register-bank init data width)
//   WDOG_LIMIT_DEFAULT - default memory-wait watchdog limit
//   WAIT_CW            - width of the memory-wait counter
package proc_pkg;

    localparam int unsigned REG_AW             = 5;
    localparam int unsigned NUM_REGS           = 32;
    localparam int unsigned XLEN               = 32;
    localparam int unsigned WDOG_LIMIT_DEFAULT = 255;
    localparam int unsigned WAIT_CW            = 8;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_MEMWAIT,
        S_ERR
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard comparison.
//   i_id_rn, i_id_rm            - decode-stage source registers
//   i_id_uses_rn, i_id_uses_rm  - source operand valid flags
//   i_ex_rd                     - execute-stage destination register
//   i_ex_reg_write              - execute-stage instruction writes a register
//   i_ex_mem_to_reg             - execute-stage instruction is a load
//   o_load_use                  - decode needs a value the load has not produced yet
// Register 0 is an ordinary writable register here, so it is compared like any other.
module hazard_detect
    import proc_pkg::*;
(
    input  logic [REG_AW-1:0] i_id_rn,
    input  logic [REG_AW-1:0] i_id_rm,
    input  logic              i_id_uses_rn,
    input  logic              i_id_uses_rm,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_to_reg,
    output logic              o_load_use
);

    logic w_rn_hit;
    logic w_rm_hit;

    always_comb begin
        w_rn_hit   = i_id_uses_rn && (i_id_rn == i_ex_rd);
        w_rm_hit   = i_id_uses_rm && (i_id_rm == i_ex_rd);
        o_load_use = i_ex_mem_to_reg && i_ex_reg_write && (w_rn_hit || w_rm_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline stall/flush controller with register-bank init sequencer,
// memory-wait freeze, watchdog and stall performance counter.
//   clk, rst                          - clock; synchronous active-low reset
//   id_rn/id_rm, id_uses_rn/rm        - decode-stage sources
//   ex_rd, ex_reg_write, ex_mem_to_reg - execute-stage destination and load flags
//   ex_branch_taken                   - branch resolved taken in execute
//   mem_req, mem_ready                - MEM-stage access and its completion
//   pc_en, if_id_en, id_ex_en, ex_mem_en - stage-register enables
//   if_id_flush, id_ex_flush          - bubble insert
//   init_we, init_addr, init_data     - register-bank initialization write port
//   core_ready                        - initialization finished
//   wdog_err                          - sticky memory-timeout error
//   stall_cnt                         - saturating count of cycles with pc_en=0
module pipeline_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              init_we,
    output logic [REG_AW-1:0] init_addr,
    output logic [XLEN-1:0]   init_data,
    output logic              core_ready,
    output logic              wdog_err,
    output logic [15:0]       stall_cnt
);

    localparam logic [REG_AW-1:0]  INIT_LAST = REG_AW'(NUM_REGS - 1);
    // The watchdog trips on the frozen MEMWAIT cycle that brings the count to WDOG_LIMIT.
    localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(WDOG_LIMIT - 1);

    ctrl_state_t        r_state;
    logic [REG_AW-1:0]  r_init_addr;
    logic [WAIT_CW-1:0] r_wait_cnt;
    logic [15:0]        r_stall_cnt;
    logic               r_wdog_err;
    logic               r_core_ready;

    logic w_load_use;
    logic w_active;
    logic w_freeze;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_count_stall;

    hazard_detect u_hazard_detect (
        .i_id_rn        (id_rn),
        .i_id_rm        (id_rm),
        .i_id_uses_rn   (id_uses_rn),
        .i_id_uses_rm   (id_uses_rm),
        .i_ex_rd        (ex_rd),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_mem_to_reg(ex_mem_to_reg),
        .o_load_use     (w_load_use)
    );

    // Enable mux: freeze > branch > load-use. MEMWAIT with mem_ready behaves as RUN.
    always_comb begin
        w_active      = (r_state == S_RUN) || (r_state == S_MEMWAIT);
        w_freeze      = w_active && mem_req && !mem_ready;
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_id_ex_en    = 1'b0;
        w_ex_mem_en   = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        if (w_active && !w_freeze) begin
            if (ex_branch_taken) begin
                w_pc_en       = 1'b1;
                w_if_id_en    = 1'b1;
                w_id_ex_en    = 1'b1;
                w_ex_mem_en   = 1'b1;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                // Hold PC and IF/ID, push a bubble into ID/EX, let the load advance.
                w_id_ex_en    = 1'b1;
                w_ex_mem_en   = 1'b1;
                w_id_ex_flush = 1'b1;
            end else begin
                w_pc_en       = 1'b1;
                w_if_id_en    = 1'b1;
                w_id_ex_en    = 1'b1;
                w_ex_mem_en   = 1'b1;
            end
        end
        w_count_stall = w_active && !w_pc_en && (r_stall_cnt != 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_init_addr  <= '0;
            r_wait_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_wdog_err   <= 1'b0;
            r_core_ready <= 1'b0;
        end else begin
            if (w_count_stall) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            unique case (r_state)
                S_INIT: begin
                    r_init_addr <= r_init_addr + REG_AW'(1);
                    if (r_init_addr == INIT_LAST) begin
                        r_state      <= S_RUN;
                        r_core_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_freeze) begin
                        r_state    <= S_MEMWAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_MEMWAIT: begin
                    if (w_freeze) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_CW'(1);
                        if (r_wait_cnt == WAIT_LAST) begin
                            r_state    <= S_ERR;
                            r_wdog_err <= 1'b1;
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_ERR: begin
                    // Sticky until reset.
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Every output is forced low while reset is held, independent of state.
    always_comb begin
        pc_en       = rst & w_pc_en;
        if_id_en    = rst & w_if_id_en;
        id_ex_en    = rst & w_id_ex_en;
        ex_mem_en   = rst & w_ex_mem_en;
        if_id_flush = rst & w_if_id_flush;
        id_ex_flush = rst & w_id_ex_flush;
        init_we     = rst && (r_state == S_INIT);
        init_addr   = init_we ? r_init_addr : '0;
        init_data   = {{(XLEN - REG_AW){1'b0}}, init_addr};
        core_ready  = rst & r_core_ready;
        wdog_err    = rst & r_wdog_err;
        stall_cnt   = rst ? r_stall_cnt : '0;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed sequences, a table of RUN-state
// hazard vectors, and randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;
    import proc_pkg::*;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rn, id_rm, ex_rd;
    logic        id_uses_rn, id_uses_rm, ex_reg_write, ex_mem_to_reg, ex_branch_taken;
    logic        mem_req, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
    logic        init_we, core_ready, wdog_err;
    logic [4:0]  init_addr;
    logic [31:0] init_data;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rn          (id_rn),
        .id_rm          (id_rm),
        .id_uses_rn     (id_uses_rn),
        .id_uses_rm     (id_uses_rm),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .init_we        (init_we),
        .init_addr      (init_addr),
        .init_data      (init_data),
        .core_ready     (core_ready),
        .wdog_err       (wdog_err),
        .stall_cnt      (stall_cnt)
    );

    typedef struct packed {
        logic        pc, ifid, idex, exmem, fl_ifid, fl_idex, we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rdy, err;
        logic [15:0] sc;
    } outs_t;

    typedef struct {
        logic [4:0] rn, rm, rd;
        logic       urn, urm, rw, m2r, br;
        logic [5:0] exp;
        string      name;
    } vec_t;

    // Reference model: cycles since reset release, frozen-cycle streak, error, stalls.
    int    m_cyc    = 0;
    int    m_streak = 0;
    int    m_stalls = 0;
    bit    m_err    = 1'b0;
    outs_t last;

    function automatic outs_t actual();
        outs_t a;
        a = '{pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, init_we,
              init_addr, init_data, core_ready, wdog_err, stall_cnt};
        return a;
    endfunction

    function automatic logic [5:0] en6(input outs_t o);
        return {o.pc, o.ifid, o.idex, o.exmem, o.fl_ifid, o.fl_idex};
    endfunction

    function automatic outs_t model_expect();
        outs_t e;
        bit    frozen, hz;
        e = '0;
        if (!rst) return e;
        if (m_cyc < 32) begin
            e.we   = 1'b1;
            e.addr = 5'(m_cyc);
            e.data = 32'(m_cyc);
            return e;
        end
        e.rdy = 1'b1;
        e.sc  = 16'(m_stalls);
        if (m_err) begin
            e.err = 1'b1;
            return e;
        end
        frozen = mem_req && !mem_ready;
        hz = ex_mem_to_reg && ex_reg_write &&
             ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
        if (frozen) begin
            // everything held
        end else if (ex_branch_taken) begin
            {e.pc, e.ifid, e.idex, e.exmem, e.fl_ifid, e.fl_idex} = 6'b111111;
        end else if (hz) begin
            {e.pc, e.ifid, e.idex, e.exmem, e.fl_ifid, e.fl_idex} = 6'b001101;
        end else begin
            {e.pc, e.ifid, e.idex, e.exmem, e.fl_ifid, e.fl_idex} = 6'b111100;
        end
        return e;
    endfunction

    task automatic model_update(input outs_t e);
        if (!rst) begin
            m_cyc = 0; m_streak = 0; m_stalls = 0; m_err = 1'b0;
        end else if (m_cyc < 32) begin
            m_cyc++;
        end else if (!m_err) begin
            if (!e.pc && m_stalls < 65535) m_stalls++;
            if (mem_req && !mem_ready) begin
                m_streak++;
                // one frozen RUN cycle plus LIMIT frozen wait cycles
                if (m_streak == int'(LIMIT) + 1) m_err = 1'b1;
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: predict, sample at negedge, compare, then advance the model at posedge.
    task automatic cycle(input string name);
        outs_t e;
        e = model_expect();
        @(negedge clk);
        last = actual();
        check(name, 64'(last), 64'(e));
        @(posedge clk);
        model_update(e);
        #1;
    endtask

    task automatic idle();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
        id_uses_rn = 1'b0; id_uses_rm = 1'b0;
        ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle("in_reset");
        check("reset_outputs_zero", 64'(last), 64'd0);
        cycle("in_reset");
        rst = 1'b1;
    endtask

    task automatic run_init(input int from);
        for (int i = from; i < 32; i++) begin
            cycle("init");
            check("init_addr", 64'({last.we, last.addr, last.data}), 64'({1'b1, 5'(i), 32'(i)}));
        end
    endtask

    task automatic set_load_use(input logic br);
        ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
        id_rn = 5'd7; id_uses_rn = 1'b1; ex_branch_taken = br;
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111100, "no_load"};
        vecs[1] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b001101, "lu_rn"};
        vecs[2] = '{5'd0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b001101, "lu_rm"};
        vecs[3] = '{5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b111100, "unused_src"};
        vecs[4] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b111100, "no_regwrite"};
        vecs[5] = '{5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b001101, "r0_hazard"};
        vecs[6] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b111111, "branch"};
        vecs[7] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b111111, "branch_lu"};
        vecs[8] = '{5'd5, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b001101, "lu_r31"};
        vecs[9] = '{5'd6, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111100, "mismatch"};

        idle();
        do_reset();
        run_init(0);
        cycle("first_run");
        check("ready_after_init", 64'({last.rdy, en6(last)}), 64'({1'b1, 6'b111100}));

        // Load-use stall, then branch overriding the same hazard.
        set_load_use(1'b0);
        cycle("load_use");
        check("load_use_en", 64'(en6(last)), 64'(6'b001101));
        idle();
        cycle("after_lu");
        check("stall_after_lu", 64'(last.sc), 64'd1);
        set_load_use(1'b1);
        cycle("branch_lu");
        check("branch_lu_en", 64'(en6(last)), 64'(6'b111111));
        idle();
        cycle("after_branch_lu");
        check("stall_after_branch", 64'(last.sc), 64'd1);

        // Three frozen cycles, then the ready cycle resumes.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("mem_wait");
            check("mem_wait_en", 64'(en6(last)), 64'd0);
        end
        mem_ready = 1'b1;
        cycle("mem_ready");
        check("mem_ready_en", 64'(en6(last)), 64'(6'b111100));
        idle();
        cycle("after_mem");
        check("stall_after_mem", 64'(last.sc), 64'd4);

        for (int i = 0; i < 10; i++) begin
            idle();
            id_rn = vecs[i].rn; id_rm = vecs[i].rm; ex_rd = vecs[i].rd;
            id_uses_rn = vecs[i].urn; id_uses_rm = vecs[i].urm;
            ex_reg_write = vecs[i].rw; ex_mem_to_reg = vecs[i].m2r;
            ex_branch_taken = vecs[i].br;
            cycle(vecs[i].name);
            check(vecs[i].name, 64'(en6(last)), 64'(vecs[i].exp));
        end

        // Watchdog: fresh init, then memory never completes.
        idle();
        do_reset();
        run_init(0);
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < int'(LIMIT) + 1; i++) begin
            cycle("wdog_wait");
            check("wdog_wait_en", 64'({last.err, en6(last)}), 64'd0);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle("wdog_err");
            check("wdog_err_held", 64'({last.err, en6(last)}), 64'({1'b1, 6'b0}));
        end
        rst = 1'b0;
        cycle("wdog_rst");
        rst = 1'b1;
        cycle("wdog_reinit");
        check("wdog_reinit_addr0", 64'({last.we, last.addr, last.err}), 64'({1'b1, 5'd0, 1'b0}));
        run_init(1);

        // Reset in the middle of initialization.
        do_reset();
        run_init(0);
        do_reset();
        for (int i = 0; i < 12; i++) cycle("init_partial");
        rst = 1'b0;
        cycle("mid_init_rst");
        check("mid_init_rst_we", 64'({last.we, last.addr}), 64'd0);
        rst = 1'b1;
        cycle("mid_init_restart");
        check("mid_init_addr0", 64'({last.we, last.addr}), 64'({1'b1, 5'd0}));
        run_init(1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            id_rn = 5'($urandom_range(0, 3));
            id_rm = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            id_uses_rn = 1'($urandom_range(0, 1));
            id_uses_rm = 1'($urandom_range(0, 1));
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_mem_to_reg = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_req = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_err) rst = ($urandom_range(0, 3) != 0);
            else rst = ($urandom_range(0, 299) != 0);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
